// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file: depth derivation,
// default data/address types and a population count used for busy accounting.
package regfile_pkg;

    function automatic int DEPTH_OF(input int addr_w);
        return 1 << addr_w;
    endfunction

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 6;
    localparam int RF_DEPTH  = DEPTH_OF(RF_ADDR_W);

    typedef logic [RF_DATA_W-1:0] rf_data_t;
    typedef logic [RF_ADDR_W-1:0] rf_addr_t;

    function automatic int popcount(input logic [RF_DEPTH-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < RF_DEPTH; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Per-register busy scoreboard: issue marks a destination pending, writeback clears it.
// busy_cnt is kept incrementally so it tracks popcount(busy) without an adder tree.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = 6,
    parameter int N_WR     = 2,
    parameter int ZERO_REG = 1,
    parameter int DEPTH    = DEPTH_OF(ADDR_W)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   iss_en,
    input  logic [ADDR_W-1:0]      iss_addr,
    input  logic [N_WR-1:0]        wr_en,
    input  logic [N_WR*ADDR_W-1:0] wr_addr,
    output logic [DEPTH-1:0]       busy,
    output logic [ADDR_W:0]        busy_cnt
);

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [ADDR_W:0]  cnt_q, cnt_d;
    logic [ADDR_W:0]  n_clr;
    logic [N_WR-1:0]  clr;
    logic             iss_ok;

    always_comb begin
        iss_ok = iss_en && !(ZERO_REG != 0 && iss_addr == '0);
        busy_d = busy_q;
        clr    = '0;
        n_clr  = '0;
        for (int k = 0; k < N_WR; k++) begin
            if (wr_en[k]) begin
                busy_d[wr_addr[k*ADDR_W +: ADDR_W]] = 1'b0;
                clr[k] = busy_q[wr_addr[k*ADDR_W +: ADDR_W]]
                         && !(iss_ok && iss_addr == wr_addr[k*ADDR_W +: ADDR_W]);
                // Only the highest-index port hitting an address counts its clear.
                for (int j = k + 1; j < N_WR; j++) begin
                    if (wr_en[j] && wr_addr[j*ADDR_W +: ADDR_W] == wr_addr[k*ADDR_W +: ADDR_W]) begin
                        clr[k] = 1'b0;
                    end
                end
            end
            n_clr = n_clr + {{ADDR_W{1'b0}}, clr[k]};
        end
        // A new issue outranks a same-cycle writeback to the same register.
        if (iss_ok) begin
            busy_d[iss_addr] = 1'b1;
        end
        cnt_d = cnt_q + {{ADDR_W{1'b0}}, (iss_ok && !busy_q[iss_addr])} - n_clr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy     = busy_q;
    assign busy_cnt = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with highest-port-wins writes, optional same-cycle
// write-to-read bypass, optional hardwired zero register and a busy scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 6,
    parameter int N_RD     = 2,
    parameter int N_WR     = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_WR-1:0]        wr_en,
    input  logic [N_WR*ADDR_W-1:0] wr_addr,
    input  logic [N_WR*DATA_W-1:0] wr_data,
    input  logic [N_RD*ADDR_W-1:0] rd_addr,
    output logic [N_RD*DATA_W-1:0] rd_data,
    output logic [N_RD-1:0]        rd_busy,
    input  logic                   iss_en,
    input  logic [ADDR_W-1:0]      iss_addr,
    output logic [ADDR_W:0]        busy_cnt
);

    localparam int DEPTH = DEPTH_OF(ADDR_W);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rv;

    // Later ports overwrite earlier ones, giving highest-index priority.
    always_comb begin
        regs_d = regs_q;
        for (int k = 0; k < N_WR; k++) begin
            if (wr_en[k] && !(ZERO_REG != 0 && wr_addr[k*ADDR_W +: ADDR_W] == '0)) begin
                regs_d[wr_addr[k*ADDR_W +: ADDR_W]] = wr_data[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        ra      = '0;
        rv      = '0;
        for (int i = 0; i < N_RD; i++) begin
            ra = rd_addr[i*ADDR_W +: ADDR_W];
            rv = regs_q[ra];
            if (BYPASS != 0) begin
                for (int k = 0; k < N_WR; k++) begin
                    if (wr_en[k] && wr_addr[k*ADDR_W +: ADDR_W] == ra) begin
                        rv = wr_data[k*DATA_W +: DATA_W];
                    end
                end
            end
            if (ZERO_REG != 0 && ra == '0) begin
                rv = '0;
            end
            rd_data[i*DATA_W +: DATA_W] = rv;
            rd_busy[i]                  = busy[ra];
        end
    end

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .N_WR     (N_WR),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .busy     (busy),
        .busy_cnt (busy_cnt)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a bypass/zero-reg instance and a plain instance share stimulus;
// expected values are queued at drive time and popped when outputs are sampled.
module tb_regfile_mp;
    import regfile_pkg::*;

    typedef struct {
        string       name;
        logic [63:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  wr_en;
    logic [11:0] wr_addr;
    logic [63:0] wr_data;
    logic [11:0] rd_addr;
    logic        iss_en;
    rf_addr_t    iss_addr;
    logic [63:0] rd_data_a, rd_data_b;
    logic [1:0]  rd_busy_a, rd_busy_b;
    logic [6:0]  busy_cnt_a, busy_cnt_b;

    exp_t             q[$];
    exp_t             e;
    logic [RF_DEPTH-1:0] m_busy;
    int               n_chk = 0;
    int               n_err = 0;

    always #5 clk = ~clk;

    regfile_mp #(.ZERO_REG(1), .BYPASS(1)) u_dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .iss_en(iss_en), .iss_addr(iss_addr), .busy_cnt(busy_cnt_a)
    );

    regfile_mp #(.ZERO_REG(0), .BYPASS(0)) u_dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .iss_en(iss_en), .iss_addr(iss_addr), .busy_cnt(busy_cnt_b)
    );

    task automatic push(input string n, input logic [63:0] v);
        q.push_back('{name: n, val: v});
    endtask

    task automatic idle();
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        iss_en   = 1'b0;
        iss_addr = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rd_addr = '0;
        rst     = 1'b1;
        wr_en   = 2'b01;
        wr_addr = {6'd0, 6'd1};
        wr_data = {32'h0, 32'hFFFF_FFFF};
        iss_en  = 1'b1;
        iss_addr = 6'd2;
        next_cycle();
        rst = 1'b0;
        idle();
        for (int a = 0; a < 64; a++) begin
            rd_addr = {6'(63 - a), 6'(a)};
            push($sformatf("rst_data_%0d", a), 64'h0);
            push($sformatf("rst_busy_%0d", a), 64'h0);
            push($sformatf("rst_cnt_%0d", a), 64'h0);
            @(negedge clk);
            e = q.pop_front(); n_chk++;
            if (rd_data_a !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, rd_data_a, e.val); end
            e = q.pop_front(); n_chk++;
            if ({62'd0, rd_busy_a} !== e.val) begin n_err++; $display("FAIL %s: got %b want %0h", e.name, rd_busy_a, e.val); end
            e = q.pop_front(); n_chk++;
            if ({57'd0, busy_cnt_a} !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, busy_cnt_a, e.val); end
        end
    endtask

    task automatic test_write_priority();
        next_cycle();
        wr_en   = 2'b11;
        wr_addr = {6'd5, 6'd5};
        wr_data = {32'h1234_5678, 32'hDEAD_BEEF};
        next_cycle();
        idle();
        rd_addr = {6'd5, 6'd5};
        push("wprio_a", 64'h1234_5678_1234_5678);
        push("wprio_b", 64'h1234_5678_1234_5678);
        @(negedge clk);
        e = q.pop_front(); n_chk++;
        if (rd_data_a !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, rd_data_a, e.val); end
        e = q.pop_front(); n_chk++;
        if (rd_data_b !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, rd_data_b, e.val); end
    endtask

    task automatic test_bypass();
        next_cycle();
        wr_en   = 2'b01;
        wr_addr = {6'd0, 6'd9};
        wr_data = {32'h0, 32'hA5A5_A5A5};
        rd_addr = {6'd5, 6'd9};
        push("byp_on", 64'h1234_5678_A5A5_A5A5);
        push("byp_off", 64'h1234_5678_0000_0000);
        @(negedge clk);
        e = q.pop_front(); n_chk++;
        if (rd_data_a !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, rd_data_a, e.val); end
        e = q.pop_front(); n_chk++;
        if (rd_data_b !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, rd_data_b, e.val); end
        // Both ports hit one address: the port-1 data must be forwarded.
        next_cycle();
        wr_en   = 2'b11;
        wr_addr = {6'd10, 6'd10};
        wr_data = {32'h2222_2222, 32'h1111_1111};
        rd_addr = {6'd9, 6'd10};
        push("byp_prio_a", 64'hA5A5_A5A5_2222_2222);
        push("byp_prio_b", 64'hA5A5_A5A5_0000_0000);
        @(negedge clk);
        e = q.pop_front(); n_chk++;
        if (rd_data_a !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, rd_data_a, e.val); end
        e = q.pop_front(); n_chk++;
        if (rd_data_b !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, rd_data_b, e.val); end
        next_cycle();
        idle();
        rd_addr = {6'd9, 6'd10};
        push("byp_store_b", 64'hA5A5_A5A5_2222_2222);
        @(negedge clk);
        e = q.pop_front(); n_chk++;
        if (rd_data_b !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, rd_data_b, e.val); end
    endtask

    task automatic test_zero_reg();
        next_cycle();
        wr_en    = 2'b01;
        wr_addr  = {6'd0, 6'd0};
        wr_data  = {32'h0, 32'hFFFF_FFFF};
        iss_en   = 1'b1;
        iss_addr = 6'd0;
        rd_addr  = {6'd0, 6'd0};
        push("zero_same_a", 64'h0);
        @(negedge clk);
        e = q.pop_front(); n_chk++;
        if (rd_data_a !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, rd_data_a, e.val); end
        next_cycle();
        idle();
        push("zero_next_a", 64'h0);
        push("zero_cnt_a", 64'h0);
        push("zero_next_b", 64'h0000_0000_FFFF_FFFF);
        push("zero_cnt_b", 64'h1);
        push("zero_busy_b", 64'h3);
        @(negedge clk);
        e = q.pop_front(); n_chk++;
        if (rd_data_a !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, rd_data_a, e.val); end
        e = q.pop_front(); n_chk++;
        if ({57'd0, busy_cnt_a} !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, busy_cnt_a, e.val); end
        e = q.pop_front(); n_chk++;
        if ({32'd0, rd_data_b[31:0]} !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, rd_data_b[31:0], e.val); end
        e = q.pop_front(); n_chk++;
        if ({57'd0, busy_cnt_b} !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, busy_cnt_b, e.val); end
        e = q.pop_front(); n_chk++;
        if ({62'd0, rd_busy_b} !== e.val) begin n_err++; $display("FAIL %s: got %b want %0h", e.name, rd_busy_b, e.val); end
        // Writeback to address 0 releases the plain instance's busy flag.
        next_cycle();
        wr_en   = 2'b10;
        wr_addr = {6'd0, 6'd0};
        wr_data = '0;
        next_cycle();
        idle();
        push("zero_clr_b", 64'h0);
        @(negedge clk);
        e = q.pop_front(); n_chk++;
        if ({57'd0, busy_cnt_b} !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, busy_cnt_b, e.val); end
    endtask

    task automatic test_scoreboard();
        logic [5:0] seq [3];
        seq = '{6'd3, 6'd4, 6'd7};
        m_busy = '0;
        rd_addr = {6'd4, 6'd3};
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            idle();
            iss_en   = 1'b1;
            iss_addr = seq[i];
            push($sformatf("sb_cnt_%0d", i), 64'(popcount(m_busy)));
            push($sformatf("sb_rdbusy_%0d", i), {62'd0, m_busy[4], m_busy[3]});
            @(negedge clk);
            e = q.pop_front(); n_chk++;
            if ({57'd0, busy_cnt_a} !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, busy_cnt_a, e.val); end
            e = q.pop_front(); n_chk++;
            if ({62'd0, rd_busy_a} !== e.val) begin n_err++; $display("FAIL %s: got %b want %0h", e.name, rd_busy_a, e.val); end
            m_busy[seq[i]] = 1'b1;
        end
        next_cycle();
        iss_en   = 1'b1;
        iss_addr = 6'd3;
        wr_en    = 2'b11;
        wr_addr  = {6'd4, 6'd3};
        wr_data  = {32'h4444_4444, 32'h3333_3333};
        push("sb_cnt_3", 64'(popcount(m_busy)));
        @(negedge clk);
        e = q.pop_front(); n_chk++;
        if ({57'd0, busy_cnt_a} !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, busy_cnt_a, e.val); end
        m_busy[4] = 1'b0;
        next_cycle();
        idle();
        push("sb_mix_cnt", 64'(popcount(m_busy)));
        push("sb_mix_busy", 64'h1);
        @(negedge clk);
        e = q.pop_front(); n_chk++;
        if ({57'd0, busy_cnt_a} !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, busy_cnt_a, e.val); end
        e = q.pop_front(); n_chk++;
        if ({62'd0, rd_busy_a} !== e.val) begin n_err++; $display("FAIL %s: got %b want %0h", e.name, rd_busy_a, e.val); end
        next_cycle();
        wr_en   = 2'b11;
        wr_addr = {6'd7, 6'd7};
        next_cycle();
        idle();
        m_busy[7] = 1'b0;
        push("sb_dual_clr_a", 64'h1);
        push("sb_dual_clr_b", 64'(popcount(m_busy)));
        @(negedge clk);
        e = q.pop_front(); n_chk++;
        if ({57'd0, busy_cnt_a} !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, busy_cnt_a, e.val); end
        e = q.pop_front(); n_chk++;
        if ({57'd0, busy_cnt_b} !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, busy_cnt_b, e.val); end
        // Re-issue of a busy register plus a write to an idle one: count unchanged.
        next_cycle();
        iss_en   = 1'b1;
        iss_addr = 6'd3;
        wr_en    = 2'b01;
        wr_addr  = {6'd0, 6'd20};
        next_cycle();
        idle();
        rd_addr = {6'd20, 6'd3};
        push("sb_reiss_cnt", 64'(popcount(m_busy)));
        push("sb_reiss_busy", 64'h1);
        @(negedge clk);
        e = q.pop_front(); n_chk++;
        if ({57'd0, busy_cnt_a} !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, busy_cnt_a, e.val); end
        e = q.pop_front(); n_chk++;
        if ({62'd0, rd_busy_a} !== e.val) begin n_err++; $display("FAIL %s: got %b want %0h", e.name, rd_busy_a, e.val); end
    endtask

    task automatic test_mid_reset();
        next_cycle();
        iss_en   = 1'b1;
        iss_addr = 6'd11;
        next_cycle();
        iss_addr = 6'd12;
        next_cycle();
        idle();
        push("mr_pre_cnt", 64'h3);
        @(negedge clk);
        e = q.pop_front(); n_chk++;
        if ({57'd0, busy_cnt_a} !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, busy_cnt_a, e.val); end
        next_cycle();
        rst      = 1'b1;
        wr_en    = 2'b01;
        wr_addr  = {6'd0, 6'd5};
        wr_data  = {32'h0, 32'hCAFE_F00D};
        iss_en   = 1'b1;
        iss_addr = 6'd13;
        next_cycle();
        rst = 1'b0;
        idle();
        rd_addr = {6'd9, 6'd5};
        push("mr_data_a", 64'h0);
        push("mr_data_b", 64'h0);
        push("mr_cnt_a", 64'h0);
        push("mr_cnt_b", 64'h0);
        @(negedge clk);
        e = q.pop_front(); n_chk++;
        if (rd_data_a !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, rd_data_a, e.val); end
        e = q.pop_front(); n_chk++;
        if (rd_data_b !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, rd_data_b, e.val); end
        e = q.pop_front(); n_chk++;
        if ({57'd0, busy_cnt_a} !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, busy_cnt_a, e.val); end
        e = q.pop_front(); n_chk++;
        if ({57'd0, busy_cnt_b} !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, busy_cnt_b, e.val); end
        rd_addr = {6'd13, 6'd11};
        push("mr_busy_a", 64'h0);
        @(negedge clk);
        e = q.pop_front(); n_chk++;
        if ({62'd0, rd_busy_a} !== e.val) begin n_err++; $display("FAIL %s: got %b want %0h", e.name, rd_busy_a, e.val); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_priority();
        test_bypass();
        test_zero_reg();
        test_scoreboard();
        test_mid_reset();
        n_chk++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL queue_drain: got %0d entries want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
